// File: rtl/ct_f_spsram_param.sv
// ----------------------------------------------------------------------------
// ct_f_spsram_param
//
// Parametrised single-port synchronous SRAM wrapper for the L1/L2 tag and data
// arrays. It supports bank-granular write enables and write-first read data.
// The address is held while the macro is deselected, and the read data is
// held between accesses. After every reset, a sequencer clears the whole
// array to INIT_VALUE. INIT_BUSY is high while the clear runs, and all
// accesses are ignored during that time.
//
// Optional feature: define CT_SPSRAM_OUT_REG_EN to add a DATA_WIDTH output
// register after the array output latch. This makes read latency 2 cycles.
//
// Parameters:
//   DATA_WIDTH  total word width
//   ADDR_WIDTH  address width, depth = 2**ADDR_WIDTH
//   BANK_WIDTH  bits per bank; must divide DATA_WIDTH
//   INIT_VALUE  BANK_WIDTH-bit pattern written to every bank during clear
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset, restarts the array clear
//   A          address
//   CEN        chip enable, active-low
//   GWEN       global write enable, active-low
//   WEN        per-bit write enable, active-low; bank b uses only the top bit
//              of its bank, WEN[(b+1)*BANK_WIDTH-1]
//   D          write data
//   Q          read data (write-first, held while CEN=1)
//   INIT_BUSY  array clear in progress
// ----------------------------------------------------------------------------
module ct_f_spsram_param #(
  parameter int DATA_WIDTH = 22,
  parameter int ADDR_WIDTH = 9,
  parameter int BANK_WIDTH = 11,
  parameter logic [BANK_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  INIT_BUSY
);

  localparam int NUM_BANKS = DATA_WIDTH / BANK_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_busy;
  logic [ADDR_WIDTH-1:0]   r_addr_hold;
  logic [DATA_WIDTH-1:0]   r_q_p1;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_in_clear;
  logic                    w_clear_wr;
  logic                    w_access;
  logic                    w_write;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_rd_word;
  logic [DATA_WIDTH-1:0]   w_mem_wdata;
  logic [DATA_WIDTH-1:0]   w_q_next;
  logic [NUM_BANKS-1:0]    w_bank_wr;
  logic [NUM_BANKS-1:0]    w_bank_we;
  logic                    w_wen_unused;

  // Only the top WEN bit of each bank is meaningful. The rest are folded
  // here so they are visibly consumed.
  assign w_wen_unused = ^WEN;

  // RST wins over both the clear write and any user access.
  assign w_in_clear = (r_state == S_CLEAR);
  assign w_clear_wr = w_in_clear && !RST;
  assign w_access   = !w_in_clear && !CEN && !RST;
  assign w_write    = w_access && !GWEN;

  // Array address: live A while selected, held address while deselected.
  assign w_addr     = CEN ? r_addr_hold : A;
  assign w_mem_addr = w_clear_wr ? r_clr_cnt : w_addr;
  assign w_rd_word  = r_mem[w_addr];

  always_comb begin
    w_bank_wr   = '0;
    w_bank_we   = '0;
    w_mem_wdata = '0;
    w_q_next    = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_wr[b] = w_write && !WEN[(b+1)*BANK_WIDTH-1];
      w_bank_we[b] = w_clear_wr || w_bank_wr[b];
      w_mem_wdata[b*BANK_WIDTH +: BANK_WIDTH] =
        w_clear_wr ? INIT_VALUE : D[b*BANK_WIDTH +: BANK_WIDTH];
      // Write-first: a bank being written shows D, others show stored data.
      w_q_next[b*BANK_WIDTH +: BANK_WIDTH] =
        w_bank_wr[b] ? D[b*BANK_WIDTH +: BANK_WIDTH]
                     : w_rd_word[b*BANK_WIDTH +: BANK_WIDTH];
    end
  end

  // Array storage (no reset; contents come from the clear sequencer).
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_bank_we[b]) begin
        r_mem[w_mem_addr][b*BANK_WIDTH +: BANK_WIDTH] <=
          w_mem_wdata[b*BANK_WIDTH +: BANK_WIDTH];
      end
    end
  end

  // Stage p1: clear sequencer, address hold, array output latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_busy      <= 1'b1;
      r_q_p1      <= '0;
      r_addr_hold <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_q_p1 <= '0;
          r_busy <= 1'b1;
          // The last address is detected as all-ones. The counter stops
          // there instead of wrapping.
          if (&r_clr_cnt) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          // S_IDLE is only reachable through corruption and behaves as S_DONE.
          r_busy <= 1'b0;
          if (w_access) begin
            r_addr_hold <= A;
            r_q_p1      <= w_q_next;
          end
        end
      endcase
    end
  end

  assign INIT_BUSY = r_busy;

`ifdef CT_SPSRAM_OUT_REG_EN
  logic                  r_acc_p1;
  logic [DATA_WIDTH-1:0] r_q_p2;

  // Stage p2: the output register loads only in the cycle after an access,
  // so Q still holds its value between accesses.
  always_ff @(posedge CLK) begin
    if (RST || w_in_clear) begin
      r_acc_p1 <= 1'b0;
      r_q_p2   <= '0;
    end else begin
      r_acc_p1 <= w_access;
      if (r_acc_p1) begin
        r_q_p2 <= r_q_p1;
      end
    end
  end

  assign Q = r_q_p2;
`else
  assign Q = r_q_p1;
`endif

endmodule

// File: tb/tb_ct_f_spsram_param.sv
module tb_ct_f_spsram_param;

`ifdef CT_SPSRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [8:0]  A;
  logic        CEN;
  logic        GWEN;
  logic [21:0] WEN;
  logic [21:0] D;
  logic [21:0] Q;
  logic        INIT_BUSY;

  int checks = 0;
  int errors = 0;

  ct_f_spsram_param dut (
    .CLK(CLK), .RST(RST), .A(A), .CEN(CEN), .GWEN(GWEN),
    .WEN(WEN), .D(D), .Q(Q), .INIT_BUSY(INIT_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        gwen;
    logic [8:0]  a;
    logic [21:0] d;
    logic [21:0] wen;
    logic [21:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // One access cycle, then deselect; Q is valid once LAT edges have passed.
  task automatic access(input logic gwen, input logic [8:0] a,
                        input logic [21:0] d, input logic [21:0] wen);
    A = a; CEN = 1'b0; GWEN = gwen; D = d; WEN = wen;
    tick();
    CEN = 1'b1; GWEN = 1'b1;
    if (LAT == 2) tick();
  endtask

  // Counts edges until INIT_BUSY falls, bounded.
  task automatic count_busy(output int n, output logic q_bad);
    n = 0;
    q_bad = 1'b0;
    while (INIT_BUSY && n < 1000) begin
      tick();
      n++;
      if (Q !== 22'h0) q_bad = 1'b1;
    end
  endtask

  initial begin
    int   n;
    logic q_bad;

    vt[0]  = '{1'b0, 9'h1A5, 22'h3FFFFF, 22'h3FFBFF, 22'h0007FF}; // bank0 only
    vt[1]  = '{1'b1, 9'h1A5, 22'h000000, 22'h3FFFFF, 22'h0007FF};
    vt[2]  = '{1'b0, 9'h010, 22'h012345, 22'h000000, 22'h012345}; // both banks
    vt[3]  = '{1'b0, 9'h020, 22'h3ABCDE, 22'h1FFFFF, 22'h3AB800}; // bank1 only
    vt[4]  = '{1'b1, 9'h020, 22'h000000, 22'h3FFFFF, 22'h3AB800};
    vt[5]  = '{1'b0, 9'h020, 22'h000555, 22'h3FFBFF, 22'h3ABD55}; // merge
    vt[6]  = '{1'b1, 9'h020, 22'h000000, 22'h000000, 22'h3ABD55};
    vt[7]  = '{1'b1, 9'h010, 22'h3FFFFF, 22'h000000, 22'h012345}; // GWEN=1 wins
    vt[8]  = '{1'b1, 9'h0FF, 22'h000000, 22'h3FFFFF, 22'h000000};
    vt[9]  = '{1'b0, 9'h0FF, 22'h2AAAAA, 22'h000000, 22'h2AAAAA};
    vt[10] = '{1'b1, 9'h0FF, 22'h000000, 22'h3FFFFF, 22'h2AAAAA};
    vt[11] = '{1'b0, 9'h1A5, 22'h000000, 22'h1FFFFF, 22'h0007FF}; // top bank -> 0

    RST = 1'b1; CEN = 1'b1; GWEN = 1'b1; WEN = '1; A = '0; D = '0;
    repeat (3) tick();
    chk("reset_q", Q, 22'h0);
    chk("reset_busy", INIT_BUSY, 1'b1);

    // Release reset while trying to write address 0 during the clear.
    RST = 1'b0;
    A = 9'h000; D = 22'h155555; WEN = '0; GWEN = 1'b0; CEN = 1'b0;
    count_busy(n, q_bad);
    CEN = 1'b1; GWEN = 1'b1; WEN = '1;
    chk("clear_busy_cycles", n, 512);
    chk("clear_q_held_zero", q_bad, 1'b0);

    access(1'b1, 9'h000, 22'h0, '1);
    chk("clear_rd_000", Q, 22'h0);
    access(1'b1, 9'h0FF, 22'h0, '1);
    chk("clear_rd_0ff", Q, 22'h0);
    access(1'b1, 9'h1FF, 22'h0, '1);
    chk("clear_rd_1ff", Q, 22'h0);

    // Table-driven accesses.
    for (int i = 0; i < 12; i++) begin
      access(vt[i].gwen, vt[i].a, vt[i].d, vt[i].wen);
      chk($sformatf("vec%0d", i), Q, vt[i].exp);
    end

    // The write-first value is seen on the write cycle itself when back-to-back.
    if (LAT == 1) begin
      A = 9'h030; D = 22'h0ABCDE; WEN = '0; GWEN = 1'b0; CEN = 1'b0;
      tick();
      chk("b2b_write_first", Q, 22'h0ABCDE);
      GWEN = 1'b1; WEN = '1; D = '0;
      tick();
      chk("b2b_read_after_write", Q, 22'h0ABCDE);
      CEN = 1'b1;
    end

    // Read-data hold while deselected and inputs wander.
    access(1'b1, 9'h1A5, 22'h0, '1);
    chk("hold_rd_1a5", Q, 22'h0007FF);
    for (int i = 0; i < 5; i++) begin
      A = 9'($urandom); D = 22'($urandom); WEN = 22'($urandom); GWEN = 1'($urandom);
      CEN = 1'b1;
      tick();
      chk($sformatf("hold_cyc%0d", i), Q, 22'h0007FF);
    end
    GWEN = 1'b1; WEN = '1;
    access(1'b1, 9'h010, 22'h0, '1);
    chk("hold_next_rd_010", Q, 22'h012345);

    // Read latency: Q is unchanged in between when the output register exists.
    A = 9'h0FF; CEN = 1'b0; GWEN = 1'b1;
    tick();
    CEN = 1'b1;
    if (LAT == 2) begin
      chk("lat_mid_cycle", Q, 22'h012345);
      tick();
    end
    chk("lat_data", Q, 22'h2AAAAA);

    // Reset mid-clear, with a write presented on the reset edge.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (200) tick();
    chk("midclr_busy_200", INIT_BUSY, 1'b1);
    RST = 1'b1; A = 9'h1FF; D = 22'h3FFFFF; WEN = '0; GWEN = 1'b0; CEN = 1'b0;
    tick();
    RST = 1'b0; CEN = 1'b1; GWEN = 1'b1; WEN = '1;
    chk("midclr_rst_q", Q, 22'h0);
    chk("midclr_rst_busy", INIT_BUSY, 1'b1);
    count_busy(n, q_bad);
    chk("midclr_busy_cycles", n, 512);
    access(1'b1, 9'h1FF, 22'h0, '1);
    chk("midclr_rd_1ff", Q, 22'h0);
    access(1'b1, 9'h1A5, 22'h0, '1);
    chk("midclr_rd_1a5", Q, 22'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
